// File: rtl/uart_pkg.sv
// Shared UART baud-rate constants and divisor helper.
// Divisors are fixed point: integer clocks plus FRAC_W fraction bits.
package uart_pkg;

   localparam int UART_DIV_W    = 16;
   localparam int UART_FRAC_W   = 4;
   localparam int UART_OVS      = 16;
   localparam int UART_DEF_INT  = 9;
   localparam int UART_DEF_FRAC = 0;

   // Rounded clk/(baud*ovs) in units of 1/2^frac_w clock.
   // Upper bits are the integer divisor, low frac_w bits the fraction.
   function automatic logic [31:0] calc_div(
      input longint unsigned clk_hz,
      input longint unsigned baud,
      input int unsigned     ovs,
      input int unsigned     frac_w
   );
      longint unsigned w_den;
      longint unsigned w_num;
      w_den = baud * longint'(ovs);
      w_num = (clk_hz << frac_w) + (w_den >> 1);
      return 32'(w_num / w_den);
   endfunction

endpackage

// File: rtl/frac_prescaler.sv
// Fractional prescaler: divides clk by act_int + act_frac/2^FRAC_W.
// New divisors are taken only at a period boundary or while idle.
module frac_prescaler
   import uart_pkg::*;
#(
   parameter int DIV_W    = UART_DIV_W,
   parameter int FRAC_W   = UART_FRAC_W,
   parameter int DEF_INT  = UART_DEF_INT,
   parameter int DEF_FRAC = UART_DEF_FRAC
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [DIV_W-1:0]  i_div_int,
   input  logic [FRAC_W-1:0] i_div_frac,
   input  logic              i_load,
   output logic              o_tick
);

   logic [DIV_W-1:0]  r_cnt;
   logic [DIV_W-1:0]  r_act_int;
   logic [DIV_W-1:0]  r_pend_int;
   logic [FRAC_W-1:0] r_acc;
   logic [FRAC_W-1:0] r_act_frac;
   logic [FRAC_W-1:0] r_pend_frac;

   logic [FRAC_W:0]   w_sum;
   logic              w_carry;
   logic              w_idle_div;
   logic              w_run;
   logic [DIV_W-1:0]  w_last;
   logic              w_wrap;
   logic              w_swap;
   logic [DIV_W-1:0]  w_nxt_int;
   logic [FRAC_W-1:0] w_nxt_frac;

   assign w_sum      = {1'b0, r_acc} + {1'b0, r_act_frac};
   assign w_carry    = w_sum[FRAC_W];
   assign w_idle_div = (r_act_int == '0);
   assign w_run      = i_en && !w_idle_div;

   // With a carry the period stretches by one clock.
   assign w_last = w_carry ? r_act_int
                           : r_act_int - DIV_W'(1);
   assign w_wrap = w_run && (r_cnt == w_last);

   // A load landing on the wrap itself governs the new period.
   assign w_nxt_int  = i_load ? i_div_int  : r_pend_int;
   assign w_nxt_frac = i_load ? i_div_frac : r_pend_frac;
   assign w_swap     = w_wrap || !i_en || w_idle_div;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_act_int   <= DIV_W'(DEF_INT);
         r_act_frac  <= FRAC_W'(DEF_FRAC);
         r_pend_int  <= DIV_W'(DEF_INT);
         r_pend_frac <= FRAC_W'(DEF_FRAC);
      end else begin
         if (i_load) begin
            r_pend_int  <= i_div_int;
            r_pend_frac <= i_div_frac;
         end
         if (w_swap) begin
            r_act_int  <= w_nxt_int;
            r_act_frac <= w_nxt_frac;
         end
         if (!i_en) begin
            r_cnt <= '0;
            r_acc <= '0;
         end else if (w_wrap) begin
            r_cnt <= '0;
            r_acc <= w_sum[FRAC_W-1:0];
         end else if (w_run) begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

   assign o_tick = w_wrap;

endmodule

// File: rtl/baud_gen.sv
// UART baud generator: oversample tick, bit tick and rx mid-bit tick.
// Phase counters advance on each prescaler wrap; outputs are registered.
module baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_W    = UART_DIV_W,
   parameter int FRAC_W   = UART_FRAC_W,
   parameter int OVS      = UART_OVS,
   parameter int DEF_INT  = UART_DEF_INT,
   parameter int DEF_FRAC = UART_DEF_FRAC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              load,
   input  logic              rx_restart,
   output logic              en_rx,
   output logic              en_tx,
   output logic              rx_mid
);

   localparam int PH_W = $clog2(OVS);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVS / 2 - 1);

   logic            w_tick;
   logic [PH_W-1:0] r_tx_ph;
   logic [PH_W-1:0] r_rx_ph;
   logic            r_en_rx;
   logic            r_en_tx;
   logic            r_rx_mid;

   frac_prescaler #(
      .DIV_W    (DIV_W),
      .FRAC_W   (FRAC_W),
      .DEF_INT  (DEF_INT),
      .DEF_FRAC (DEF_FRAC)
   ) u_presc (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_div_int  (div_int),
      .i_div_frac (div_frac),
      .i_load     (load),
      .o_tick     (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_ph  <= '0;
         r_rx_ph  <= '0;
         r_en_rx  <= 1'b0;
         r_en_tx  <= 1'b0;
         r_rx_mid <= 1'b0;
      end else begin
         r_en_rx  <= w_tick;
         r_en_tx  <= w_tick && (r_tx_ph == PH_LAST);
         r_rx_mid <= w_tick && (r_rx_ph == PH_MID)
                     && !rx_restart;
         if (w_tick) begin
            r_tx_ph <= (r_tx_ph == PH_LAST) ? '0
                       : r_tx_ph + PH_W'(1);
         end
         // A start edge realigns rx phase even on a tick.
         if (rx_restart) begin
            r_rx_ph <= '0;
         end else if (w_tick) begin
            r_rx_ph <= (r_rx_ph == PH_LAST) ? '0
                       : r_rx_ph + PH_W'(1);
         end
      end
   end

   assign en_rx  = r_en_rx;
   assign en_tx  = r_en_tx;
   assign rx_mid = r_rx_mid;

endmodule
